// File: rtl/aha_reset_sequencer.sv
// aha_reset_sequencer
//   Power-on / system reset sequencer with CPU deep-sleep handshake.
//   After reset sources go quiet, all resets stay low for HOLD_CYCLES edges.
//   The four domain resets are then released STAGGER edges apart (NIC, SRAM,
//   PERIPH, DMA/CGRA), and CPU_SYSRESETn follows STAGGER edges after that.
//   In RUN, the block drives the SLEEPHOLD / WIC / gated-clock handshake for
//   CPU deep sleep and wake.
//
// Ports
//   MASTER_CLK, PORESETn        clock; async active-low power-on reset
//   SYSRESETREQ, WDOG_RESET_REQ,
//   LOCKUP                      reset sources (LOCKUP gated by LOCKUP_RST_EN)
//   SLEEPDEEP, SLEEPHOLDACKn    CPU sleep status / sleep-hold ack (low = ack)
//   PMU_WIC_EN_ACK, PMU_WAKEUP  PMU handshake inputs
//   DOM_RESETn[3:0]             domain resets, active-low
//   CPU_SYSRESETn               CPU system reset, active-low
//   SLEEPHOLDREQn               sleep-hold request to CPU, active-low
//   PMU_WIC_EN_REQ              WIC-enable request to PMU
//   CPU_GCLK_EN                 CPU gated-clock enable
//   RESET_CAUSE[2:0]            sticky cause: [0] SYSRESETREQ [1] WDOG [2] LOCKUP
//   SEQ_STATE[2:0]              FSM state encoding
// All outputs come straight from flops.
module aha_reset_sequencer #(
  parameter int HOLD_CYCLES   = 16,
  parameter int STAGGER       = 4,
  parameter bit LOCKUP_RST_EN = 1'b1
) (
  input  logic       MASTER_CLK,
  input  logic       PORESETn,
  input  logic       SYSRESETREQ,
  input  logic       WDOG_RESET_REQ,
  input  logic       LOCKUP,
  input  logic       SLEEPDEEP,
  input  logic       SLEEPHOLDACKn,
  input  logic       PMU_WIC_EN_ACK,
  input  logic       PMU_WAKEUP,
  output logic [3:0] DOM_RESETn,
  output logic       CPU_SYSRESETn,
  output logic       SLEEPHOLDREQn,
  output logic       PMU_WIC_EN_REQ,
  output logic       CPU_GCLK_EN,
  output logic [2:0] RESET_CAUSE,
  output logic [2:0] SEQ_STATE
);

  typedef enum logic [2:0] {
    RST_HOLD = 3'd0,
    RELEASE  = 3'd1,
    RUN      = 3'd2,
    SLP_HOLD = 3'd3,
    WIC_REQ  = 3'd4,
    DEEP     = 3'd5,
    WAKE     = 3'd6
  } state_t;

  localparam logic [7:0] HOLD_LAST    = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] STAGGER_LAST = 8'(STAGGER - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  // Release stage: 0..3 = domain reset k next, 4 = CPU reset next. The
  // counter restarts every STAGGER edges so 5*STAGGER never overflows it.
  logic [2:0] stage_q, stage_d;
  logic [3:0] dom_q, dom_d;
  logic       cpu_q, cpu_d;
  logic       shreq_n_q, shreq_n_d;
  logic       wic_q, wic_d;
  logic       gclk_q, gclk_d;
  logic [2:0] cause_q, cause_d;

  logic [2:0] src;
  logic       rst_req;

  assign src     = {LOCKUP & LOCKUP_RST_EN, WDOG_RESET_REQ, SYSRESETREQ};
  assign rst_req = |src;

  always_ff @(posedge MASTER_CLK or negedge PORESETn) begin
    if (!PORESETn) begin
      state_q   <= RST_HOLD;
      cnt_q     <= 8'd0;
      stage_q   <= 3'd0;
      dom_q     <= 4'b0000;
      cpu_q     <= 1'b0;
      shreq_n_q <= 1'b1;
      wic_q     <= 1'b0;
      gclk_q    <= 1'b1;
      cause_q   <= 3'b000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stage_q   <= stage_d;
      dom_q     <= dom_d;
      cpu_q     <= cpu_d;
      shreq_n_q <= shreq_n_d;
      wic_q     <= wic_d;
      gclk_q    <= gclk_d;
      cause_q   <= cause_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stage_d   = stage_q;
    dom_d     = dom_q;
    cpu_d     = cpu_q;
    shreq_n_d = shreq_n_q;
    wic_d     = wic_q;
    gclk_d    = gclk_q;
    cause_d   = cause_q;

    if (state_q != RST_HOLD && rst_req) begin
      // Reset request beats any sleep/wake move taken this cycle.
      state_d   = RST_HOLD;
      dom_d     = 4'b0000;
      cpu_d     = 1'b0;
      shreq_n_d = 1'b1;
      wic_d     = 1'b0;
      gclk_d    = 1'b1;
      cause_d   = src;
    end else begin
      case (state_q)
        RST_HOLD: begin
          dom_d     = 4'b0000;
          cpu_d     = 1'b0;
          shreq_n_d = 1'b1;
          wic_d     = 1'b0;
          gclk_d    = 1'b1;
          cause_d   = cause_q | src;
          if (rst_req)                 cnt_d   = 8'd0;
          else if (cnt_q == HOLD_LAST) state_d = RELEASE;
          else                         cnt_d   = cnt_q + 8'd1;
        end
        RELEASE: begin
          if (cnt_q == STAGGER_LAST) begin
            cnt_d = 8'd0;
            if (stage_q == 3'd4) begin
              cpu_d   = 1'b1;
              state_d = RUN;
            end else begin
              dom_d[stage_q[1:0]] = 1'b1;
              stage_d = stage_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        RUN: begin
          if (SLEEPDEEP) begin
            state_d   = SLP_HOLD;
            shreq_n_d = 1'b0;
          end
        end
        SLP_HOLD: begin
          // Ack is checked first so it wins a same-cycle SLEEPDEEP drop.
          if (!SLEEPHOLDACKn) begin
            state_d = WIC_REQ;
            wic_d   = 1'b1;
          end else if (!SLEEPDEEP) begin
            state_d   = RUN;
            shreq_n_d = 1'b1;
          end
        end
        WIC_REQ: begin
          if (PMU_WIC_EN_ACK) begin
            state_d = DEEP;
            gclk_d  = 1'b0;
          end
        end
        DEEP: begin
          if (PMU_WAKEUP) begin
            state_d = WAKE;
            gclk_d  = 1'b1;
            wic_d   = 1'b0;
          end
        end
        WAKE: begin
          if (!PMU_WIC_EN_ACK) begin
            state_d   = RUN;
            shreq_n_d = 1'b1;
          end
        end
        default: begin
          // Unused encoding: recover through a full reset sequence.
          state_d   = RST_HOLD;
          dom_d     = 4'b0000;
          cpu_d     = 1'b0;
          shreq_n_d = 1'b1;
          wic_d     = 1'b0;
          gclk_d    = 1'b1;
        end
      endcase
    end

    if (state_d != state_q) begin
      cnt_d = 8'd0;
      if (state_d != RELEASE || state_q != RELEASE) stage_d = 3'd0;
    end
  end

  assign DOM_RESETn     = dom_q;
  assign CPU_SYSRESETn  = cpu_q;
  assign SLEEPHOLDREQn  = shreq_n_q;
  assign PMU_WIC_EN_REQ = wic_q;
  assign CPU_GCLK_EN    = gclk_q;
  assign RESET_CAUSE    = cause_q;
  assign SEQ_STATE      = state_q;

endmodule

// File: tb/tb_aha_reset_sequencer.sv
// Bench for aha_reset_sequencer at default parameters. Stimulus is driven
// just after each rising edge; the expected output word is queued with the
// stimulus and popped and compared 1 time unit after the next rising edge.
module tb_aha_reset_sequencer;

  logic       MASTER_CLK = 1'b0;
  logic       PORESETn;
  logic       SYSRESETREQ, WDOG_RESET_REQ, LOCKUP, SLEEPDEEP;
  logic       SLEEPHOLDACKn, PMU_WIC_EN_ACK, PMU_WAKEUP;
  logic [3:0] DOM_RESETn;
  logic       CPU_SYSRESETn, SLEEPHOLDREQn, PMU_WIC_EN_REQ, CPU_GCLK_EN;
  logic [2:0] RESET_CAUSE, SEQ_STATE;

  aha_reset_sequencer dut (
    .MASTER_CLK    (MASTER_CLK),
    .PORESETn      (PORESETn),
    .SYSRESETREQ   (SYSRESETREQ),
    .WDOG_RESET_REQ(WDOG_RESET_REQ),
    .LOCKUP        (LOCKUP),
    .SLEEPDEEP     (SLEEPDEEP),
    .SLEEPHOLDACKn (SLEEPHOLDACKn),
    .PMU_WIC_EN_ACK(PMU_WIC_EN_ACK),
    .PMU_WAKEUP    (PMU_WAKEUP),
    .DOM_RESETn    (DOM_RESETn),
    .CPU_SYSRESETn (CPU_SYSRESETn),
    .SLEEPHOLDREQn (SLEEPHOLDREQn),
    .PMU_WIC_EN_REQ(PMU_WIC_EN_REQ),
    .CPU_GCLK_EN   (CPU_GCLK_EN),
    .RESET_CAUSE   (RESET_CAUSE),
    .SEQ_STATE     (SEQ_STATE)
  );

  always #5 MASTER_CLK = ~MASTER_CLK;

  // Input word: [6] SYSRESETREQ [5] WDOG [4] LOCKUP [3] SLEEPDEEP
  //             [2] SLEEPHOLDACKn [1] PMU_WIC_EN_ACK [0] PMU_WAKEUP
  localparam logic [6:0] IDLE = 7'b0000100;

  // Output word: {DOM[3:0], CPU, SHREQn, WICREQ, GCLK, CAUSE[2:0], STATE[2:0]}
  typedef struct {
    logic [6:0]  in;
    logic [13:0] exp;
    string       name;
  } vec_t;

  int errors = 0;
  int checks = 0;
  logic [13:0] exp_q[$];
  string       name_q[$];
  vec_t        tbl[$];

  wire [13:0] act = {DOM_RESETn, CPU_SYSRESETn, SLEEPHOLDREQn, PMU_WIC_EN_REQ,
                     CPU_GCLK_EN, RESET_CAUSE, SEQ_STATE};

  function automatic logic [13:0] ex(input logic [3:0] dom, input logic cpu,
                                     input logic shn, input logic wreq,
                                     input logic gclk, input logic [2:0] cause,
                                     input logic [2:0] st);
    return {dom, cpu, shn, wreq, gclk, cause, st};
  endfunction

  function automatic vec_t mk(input logic [6:0] in, input logic [13:0] e,
                              input string nm);
    vec_t v;
    v.in = in; v.exp = e; v.name = nm;
    return v;
  endfunction

  task automatic compare(input logic [13:0] e, input string nm);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got %b required %b (t=%0t)", nm, act, e, $time);
    end
  endtask

  task automatic step(input logic [6:0] in, input logic [13:0] e,
                      input string nm);
    logic [13:0] pe;
    string       pn;
    {SYSRESETREQ, WDOG_RESET_REQ, LOCKUP, SLEEPDEEP,
     SLEEPHOLDACKn, PMU_WIC_EN_ACK, PMU_WAKEUP} = in;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge MASTER_CLK);
    #1;
    pe = exp_q.pop_front();
    pn = name_q.pop_front();
    compare(pe, pn);
  endtask

  // Full release sequence with quiet inputs, edge 1 = first edge with no
  // reset source active. Hold 16, then resets at 20/24/28/32, CPU at 36.
  task automatic boot_seq(input logic [2:0] cause, input string nm);
    logic [3:0] dom;
    logic [2:0] st;
    for (int e = 1; e <= 36; e++) begin
      for (int k = 0; k < 4; k++) dom[k] = (e >= 20 + 4 * k);
      st = (e < 16) ? 3'd0 : ((e < 36) ? 3'd1 : 3'd2);
      step(IDLE, ex(dom, e >= 36, 1'b1, 1'b0, 1'b1, cause, st),
           $sformatf("%s_edge%0d", nm, e));
    end
  endtask

  initial begin
    PORESETn = 1'b0;
    {SYSRESETREQ, WDOG_RESET_REQ, LOCKUP, SLEEPDEEP,
     SLEEPHOLDACKn, PMU_WIC_EN_ACK, PMU_WAKEUP} = IDLE;
    repeat (3) @(posedge MASTER_CLK);
    #1;
    compare(ex(4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 3'd0), "por_values");
    PORESETn = 1'b1;

    boot_seq(3'b000, "powerup");

    // Sleep/wake table, starting in RUN with cause 000.
    tbl.push_back(mk(7'b0001100, ex(4'hF,1,0,0,1,3'b000,3'd3), "slp_enter"));
    tbl.push_back(mk(7'b0001000, ex(4'hF,1,0,1,1,3'b000,3'd4), "wic_req"));
    tbl.push_back(mk(7'b0001010, ex(4'hF,1,0,1,0,3'b000,3'd5), "deep"));
    tbl.push_back(mk(7'b0000010, ex(4'hF,1,0,1,0,3'b000,3'd5), "deep_stay"));
    tbl.push_back(mk(7'b0000011, ex(4'hF,1,0,0,1,3'b000,3'd6), "wake"));
    tbl.push_back(mk(7'b0000010, ex(4'hF,1,0,0,1,3'b000,3'd6), "wake_stay"));
    tbl.push_back(mk(7'b0000100, ex(4'hF,1,1,0,1,3'b000,3'd2), "run_back"));
    tbl.push_back(mk(7'b0001100, ex(4'hF,1,0,0,1,3'b000,3'd3), "slp2"));
    tbl.push_back(mk(7'b0001100, ex(4'hF,1,0,0,1,3'b000,3'd3), "slp_wait"));
    tbl.push_back(mk(7'b0000100, ex(4'hF,1,1,0,1,3'b000,3'd2), "abort"));
    tbl.push_back(mk(7'b0000100, ex(4'hF,1,1,0,1,3'b000,3'd2), "run_idle"));
    tbl.push_back(mk(7'b0001100, ex(4'hF,1,0,0,1,3'b000,3'd3), "slp3"));
    tbl.push_back(mk(7'b0000000, ex(4'hF,1,0,1,1,3'b000,3'd4), "race_ack_wins"));
    tbl.push_back(mk(7'b0000011, ex(4'hF,1,0,1,0,3'b000,3'd5), "deep_wake_pend"));
    tbl.push_back(mk(7'b0000011, ex(4'hF,1,0,0,1,3'b000,3'd6), "deep_one_cycle"));
    tbl.push_back(mk(7'b0000100, ex(4'hF,1,1,0,1,3'b000,3'd2), "run3"));
    for (int i = 0; i < tbl.size(); i++) step(tbl[i].in, tbl[i].exp, tbl[i].name);

    // Watchdog + lockup one-cycle pulse from RUN.
    step(7'b0110100, ex(4'h0,0,1,0,1,3'b110,3'd0), "wdog_lockup_rst");
    boot_seq(3'b110, "rerelease");

    // SYSRESETREQ in DEEP, with a wake pending the same cycle.
    step(7'b0001100, ex(4'hF,1,0,0,1,3'b110,3'd3), "d_slp");
    step(7'b0001000, ex(4'hF,1,0,1,1,3'b110,3'd4), "d_wic");
    step(7'b0001010, ex(4'hF,1,0,1,0,3'b110,3'd5), "d_deep");
    step(7'b1000101, ex(4'h0,0,1,0,1,3'b001,3'd0), "deep_sysreset");
    // 8 quiet edges, then 10 edges of request: the count must restart.
    for (int i = 0; i < 8; i++)
      step(IDLE, ex(4'h0,0,1,0,1,3'b001,3'd0), "hold_quiet");
    for (int i = 0; i < 9; i++)
      step(7'b1000100, ex(4'h0,0,1,0,1,3'b001,3'd0), "hold_req");
    step(7'b1100100, ex(4'h0,0,1,0,1,3'b011,3'd0), "hold_cause_or");
    boot_seq(3'b011, "after_hold");

    // Asynchronous power-on reset while in DEEP.
    step(7'b0001100, ex(4'hF,1,0,0,1,3'b011,3'd3), "a_slp");
    step(7'b0001000, ex(4'hF,1,0,1,1,3'b011,3'd4), "a_wic");
    step(7'b0001010, ex(4'hF,1,0,1,0,3'b011,3'd5), "a_deep");
    PORESETn = 1'b0;
    #2;
    compare(ex(4'h0,0,1,0,1,3'b000,3'd0), "async_por_in_deep");
    #10;
    PORESETn = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aha_reset_sequencer.md
AHA_RESET_SEQUENCER -- requirements
Module: aha_reset_sequencer

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- HOLD_CYCLES, 16, cycles all resets stay asserted in RST_HOLD; legal 1..255.
- STAGGER, 4, cycles between successive reset releases; legal 1..255.
- LOCKUP_RST_EN, 1, when 1, LOCKUP is a reset source.

REQ-002 Ports SHALL be, one per line (name direction width meaning):
- MASTER_CLK  in  1  sole clock.
- PORESETn  in  1  reset, asynchronous, active-low.
- SYSRESETREQ  in  1  CPU system reset request.
- WDOG_RESET_REQ  in  1  watchdog reset request.
- LOCKUP  in  1  CPU lockup.
- SLEEPDEEP  in  1  CPU deep-sleep indication.
- SLEEPHOLDACKn  in  1  CPU sleep-hold acknowledge, active-low.
- PMU_WIC_EN_ACK  in  1  PMU WIC-enable acknowledge.
- PMU_WAKEUP  in  1  PMU wake request.
- DOM_RESETn  out  4  domain resets: [0] NIC, [1] SRAM, [2] PERIPH, [3] DMA/CGRA; active-low.
- CPU_SYSRESETn  out  1  CPU system reset, active-low.
- SLEEPHOLDREQn  out  1  sleep-hold request to CPU, active-low.
- PMU_WIC_EN_REQ  out  1  WIC-enable request to PMU.
- CPU_GCLK_EN  out  1  CPU gated-clock enable.
- RESET_CAUSE  out  3  [0] SYSRESETREQ, [1] WDOG, [2] LOCKUP.
- SEQ_STATE  out  3  current FSM state encoding.

REQ-003 All inputs SHALL be treated as synchronous to MASTER_CLK; all outputs SHALL be driven directly from flops.

Function
REQ-004 The FSM SHALL have these states and SEQ_STATE encodings: RST_HOLD=0, RELEASE=1, RUN=2, SLP_HOLD=3, WIC_REQ=4, DEEP=5, WAKE=6.
REQ-005 The reset request rst_req SHALL be SYSRESETREQ | WDOG_RESET_REQ | (LOCKUP & LOCKUP_RST_EN).
REQ-006 In RST_HOLD, all resets SHALL be low. An 8-bit counter SHALL count edges with rst_req low. The FSM SHALL go to RELEASE at the HOLD_CYCLES-th such edge.
REQ-007 rst_req high in RST_HOLD SHALL clear the counter to 0, extending the hold.
REQ-008 In RELEASE, the counter SHALL restart at 0. DOM_RESETn[k] SHALL rise at the (k+1)*STAGGER-th edge after entry, for k=0..3, in ascending order.
REQ-009 CPU_SYSRESETn SHALL rise at the 5*STAGGER-th edge after entry, and on that same edge the FSM SHALL go to RUN.
REQ-010 rst_req in any state other than RST_HOLD SHALL cause, on the next edge, all of the following:
- go to RST_HOLD;
- drive DOM_RESETn=0 and CPU_SYSRESETn=0;
- drive PMU_WIC_EN_REQ=0, CPU_GCLK_EN=1, SLEEPHOLDREQn=1.
REQ-011 On each transition into RST_HOLD, RESET_CAUSE SHALL load the bitwise OR of all active sources. Further sources arriving while in RST_HOLD SHALL be ORed in. RESET_CAUSE SHALL hold its value outside RST_HOLD.
REQ-012 Deep-sleep sequence:
- RUN with SLEEPDEEP=1: go to SLP_HOLD and drive SLEEPHOLDREQn=0.
- SLP_HOLD with SLEEPHOLDACKn=0: go to WIC_REQ and drive PMU_WIC_EN_REQ=1.
- WIC_REQ with PMU_WIC_EN_ACK=1: go to DEEP and drive CPU_GCLK_EN=0.
- DEEP with PMU_WAKEUP=1: go to WAKE, drive CPU_GCLK_EN=1 and PMU_WIC_EN_REQ=0.
- WAKE with PMU_WIC_EN_ACK=0: go to RUN and drive SLEEPHOLDREQn=1.
REQ-013 In SLP_HOLD, if SLEEPDEEP=0 and SLEEPHOLDACKn=1, the FSM SHALL abort to RUN with SLEEPHOLDREQn=1. If both deassert in the same cycle, the ack SHALL win and the FSM SHALL proceed to WIC_REQ.
REQ-014 If PMU_WAKEUP is already 1 on entry to DEEP, the FSM SHALL leave DEEP on the next edge. CPU_GCLK_EN SHALL be low for exactly one cycle in that case.
REQ-015 rst_req SHALL have priority over every sleep or wake transition in the same cycle.
REQ-016 The counter SHALL never wrap. It SHALL be cleared on every state change.

Reset
REQ-017 While PORESETn=0, outputs SHALL be:
- DOM_RESETn=4'b0000, CPU_SYSRESETn=0;
- SLEEPHOLDREQn=1, PMU_WIC_EN_REQ=0, CPU_GCLK_EN=1;
- RESET_CAUSE=3'b000, SEQ_STATE=0 (RST_HOLD), counter=0.
REQ-018 Assertion of PORESETn mid-sequence, including in DEEP, SHALL restore the REQ-017 values immediately and asynchronously.

Verification
REQ-019 Defaults (HOLD_CYCLES=16, STAGGER=4); edge 1 is the first MASTER_CLK edge after PORESETn rises. Required response:
- DOM_RESETn[0..3] rise at edges 20, 24, 28, 32;
- CPU_SYSRESETn rises at edge 36;
- SEQ_STATE=2 at edge 36;
- RESET_CAUSE=000.
REQ-020 In RUN, pulse WDOG_RESET_REQ and LOCKUP together for one cycle. Required response:
- all resets low on the next edge;
- RESET_CAUSE=110;
- CPU_SYSRESETn high again 36 edges later.
REQ-021 Run the full deep-sleep handshake: SLEEPDEEP=1, ack low, WIC ack high, PMU_WAKEUP, WIC ack low. Required response:
- SEQ_STATE steps 2,3,4,5,6,2;
- CPU_GCLK_EN low only while in DEEP;
- SLEEPHOLDREQn=1 at return to RUN.
REQ-022 In SLP_HOLD, drop SLEEPDEEP before the ack. Required response: RUN on the next edge, SLEEPHOLDREQn=1, PMU_WIC_EN_REQ never asserted.
REQ-023 In DEEP, assert SYSRESETREQ. Required response: on the next edge RST_HOLD, CPU_GCLK_EN=1, PMU_WIC_EN_REQ=0, RESET_CAUSE=001.
REQ-024 Hold SYSRESETREQ for 10 cycles in RST_HOLD. Required response: DOM_RESETn[0] rises 20 edges after SYSRESETREQ falls.
